// File: rtl/packet_vc_pkg.sv
// Shared packet type, field widths and width helpers for the virtual-channel packet queue.
package packet_vc_pkg;

  localparam int PKT_ID_W      = 32;
  localparam int PKT_ADDR_W    = 128;
  localparam int PKT_PAYLOAD_W = 128;
  localparam int PKT_W         = PKT_ID_W + 2 * PKT_ADDR_W + PKT_PAYLOAD_W;

  typedef struct packed {
    logic [PKT_ID_W-1:0]      id;
    logic [PKT_ADDR_W-1:0]    src;
    logic [PKT_ADDR_W-1:0]    dest;
    logic [PKT_PAYLOAD_W-1:0] payload;
  } pkt_t;

  // Channel-select width; a single channel still needs a 1-bit index.
  function automatic int ch_w(input int num_ch);
    return (num_ch < 2) ? 1 : $clog2(num_ch);
  endfunction

  function automatic int ptr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/packet_vc_queue_vc_fifo.sv
// One virtual channel: DEPTH-entry synchronous FIFO with registered occupancy and status flags.
module vc_fifo
  import packet_vc_pkg::*;
#(
  parameter int W            = PKT_W,
  parameter int DEPTH        = 16,
  parameter int AFULL_THRESH = DEPTH - 2,
  localparam int PTR_W       = ptr_w(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         full,
  output logic         afull
);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   occ;

  // The caller never pushes when full nor pops when empty; pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   occ <= occ + (PTR_W+1)'(1);
        2'b01:   occ <= occ - (PTR_W+1)'(1);
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign empty = (occ == '0);
  assign full  = (occ == (PTR_W+1)'(DEPTH));
  assign afull = (occ >= (PTR_W+1)'(AFULL_THRESH));

endmodule

// File: rtl/packet_vc_queue.sv
// Steers packets into per-destination virtual channels and drains them round-robin into one
// registered output. Handshakes: a transfer happens on a clock edge where valid && ready.
module packet_vc_queue
  import packet_vc_pkg::*;
#(
  parameter int ID_W         = PKT_ID_W,
  parameter int ADDR_W       = PKT_ADDR_W,
  parameter int PAYLOAD_W    = PKT_PAYLOAD_W,
  parameter int NUM_CH       = 4,
  parameter int DEPTH        = 16,
  parameter int AFULL_THRESH = DEPTH - 2,
  parameter int DROP_ON_FULL = 0,
  localparam int CH_W        = ch_w(NUM_CH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ID_W-1:0]      in_id,
  input  logic [ADDR_W-1:0]    in_src,
  input  logic [ADDR_W-1:0]    in_dest,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ID_W-1:0]      out_id,
  output logic [ADDR_W-1:0]    out_src,
  output logic [ADDR_W-1:0]    out_dest,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [CH_W-1:0]      out_ch,
  output logic [NUM_CH-1:0]    ch_empty,
  output logic [NUM_CH-1:0]    ch_full,
  output logic [NUM_CH-1:0]    ch_afull,
  output logic [31:0]          drop_cnt
);

  localparam int PW = ID_W + 2 * ADDR_W + PAYLOAD_W;

  logic [CH_W-1:0]   sel;
  logic              in_fire;
  logic              drop;
  logic [NUM_CH-1:0] push_en;
  logic [NUM_CH-1:0] pop_en;
  logic [PW-1:0]     head [NUM_CH];
  logic [PW-1:0]     out_data;
  logic [CH_W-1:0]   rr_last;
  logic [CH_W-1:0]   grant;
  logic [CH_W-1:0]   cand;
  logic              grant_found;
  logic              load_en;

  assign sel = in_dest[CH_W-1:0];

  // in_ready depends only on rst and the selected channel's registered full flag.
  if (DROP_ON_FULL != 0) begin : g_drop
    assign in_ready = !rst;
  end else begin : g_bp
    assign in_ready = !rst && !ch_full[sel];
  end

  assign in_fire = in_valid && in_ready;
  assign drop    = in_fire && ch_full[sel];

  always_comb begin
    push_en = '0;
    if (in_fire && !ch_full[sel]) push_en[sel] = 1'b1;
  end

  assign load_en = !out_valid || out_ready;

  // First non-empty channel after rr_last, wrapping; the last candidate is rr_last itself.
  always_comb begin
    grant_found = 1'b0;
    grant       = '0;
    cand        = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      cand = rr_last + CH_W'(i);
      if (!grant_found && !ch_empty[cand]) begin
        grant_found = 1'b1;
        grant       = cand;
      end
    end
  end

  always_comb begin
    pop_en = '0;
    if (load_en && grant_found) pop_en[grant] = 1'b1;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    vc_fifo #(
      .W            (PW),
      .DEPTH        (DEPTH),
      .AFULL_THRESH (AFULL_THRESH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_en[g]),
      .wdata ({in_id, in_src, in_dest, in_payload}),
      .pop   (pop_en[g]),
      .rdata (head[g]),
      .empty (ch_empty[g]),
      .full  (ch_full[g]),
      .afull (ch_afull[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr_last   <= CH_W'(NUM_CH - 1);
    end else if (load_en) begin
      if (grant_found) begin
        out_valid <= 1'b1;
        out_data  <= head[grant];
        out_ch    <= grant;
        rr_last   <= grant;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != 32'hFFFF_FFFF)) begin
      drop_cnt <= drop_cnt + 32'd1;
    end
  end

  assign {out_id, out_src, out_dest, out_payload} = out_data;

endmodule

// File: tb/tb_packet_vc_queue.sv
// Bench for packet_vc_queue: a backpressure instance checked every cycle against a queue-based
// channel model, plus a drop-on-full instance exercised with directed steps.
module tb_packet_vc_queue;
  import packet_vc_pkg::*;

  localparam int NCH = 4;
  localparam int DEP = 16;
  localparam int AFT = DEP - 2;
  localparam int PW  = PKT_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- backpressure instance ----------------
  logic                     in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [PKT_ID_W-1:0]      in_id = '0, out_id;
  logic [PKT_ADDR_W-1:0]    in_src = '0, in_dest = '0, out_src, out_dest;
  logic [PKT_PAYLOAD_W-1:0] in_payload = '0, out_payload;
  logic [1:0]               out_ch;
  logic [NCH-1:0]           ch_empty, ch_full, ch_afull;
  logic [31:0]              drop_cnt;

  packet_vc_queue #(.NUM_CH(NCH), .DEPTH(DEP), .DROP_ON_FULL(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_id(in_id),
    .in_src(in_src), .in_dest(in_dest), .in_payload(in_payload), .out_valid(out_valid),
    .out_ready(out_ready), .out_id(out_id), .out_src(out_src), .out_dest(out_dest),
    .out_payload(out_payload), .out_ch(out_ch), .ch_empty(ch_empty), .ch_full(ch_full),
    .ch_afull(ch_afull), .drop_cnt(drop_cnt)
  );

  // ---------------- drop-on-full instance ----------------
  logic                     d_in_valid = 1'b0, d_in_ready, d_out_valid, d_out_ready = 1'b0;
  logic [PKT_ID_W-1:0]      d_in_id = '0, d_out_id;
  logic [PKT_ADDR_W-1:0]    d_in_src = '0, d_in_dest = '0, d_out_src, d_out_dest;
  logic [PKT_PAYLOAD_W-1:0] d_in_payload = '0, d_out_payload;
  logic [1:0]               d_out_ch;
  logic [NCH-1:0]           d_ch_empty, d_ch_full, d_ch_afull;
  logic [31:0]              d_drop_cnt;

  packet_vc_queue #(.NUM_CH(NCH), .DEPTH(DEP), .DROP_ON_FULL(1)) dut_d (
    .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d_in_ready), .in_id(d_in_id),
    .in_src(d_in_src), .in_dest(d_in_dest), .in_payload(d_in_payload),
    .out_valid(d_out_valid), .out_ready(d_out_ready), .out_id(d_out_id),
    .out_src(d_out_src), .out_dest(d_out_dest), .out_payload(d_out_payload),
    .out_ch(d_out_ch), .ch_empty(d_ch_empty), .ch_full(d_ch_full), .ch_afull(d_ch_afull),
    .drop_cnt(d_drop_cnt)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  logic [PW-1:0] mq [NCH][$];   // packets waiting in each channel
  bit            m_ov  = 1'b0;  // output register occupied
  logic [PW-1:0] m_out = '0;
  int            m_ch  = 0;
  int            m_rr  = NCH - 1;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) mq[c].delete();
    m_ov = 1'b0; m_out = '0; m_ch = 0; m_rr = NCH - 1;
  endtask

  // One clock of the model: grant from the contents present before the edge, then enqueue.
  task automatic model_edge();
    int  sel;
    bit  acc;
    bit  found;
    int  c;
    if (rst) begin
      model_reset();
      return;
    end
    sel = int'(in_dest[1:0]);
    acc = in_valid && (mq[sel].size() < DEP);
    if (!m_ov || out_ready) begin
      found = 1'b0;
      for (int i = 1; i <= NCH; i++) begin
        c = (m_rr + i) % NCH;
        if (!found && mq[c].size() > 0) begin
          m_out = mq[c].pop_front();
          m_ch  = c;
          m_rr  = c;
          found = 1'b1;
        end
      end
      m_ov = found;
    end
    if (acc) mq[sel].push_back({in_id, in_src, in_dest, in_payload});
  endtask

  // Called right after a negedge with inputs already driven.
  task automatic tick();
    logic [NCH-1:0] e_empty, e_full, e_afull;
    bit e_rdy;
    #1;
    e_rdy = !rst && (mq[int'(in_dest[1:0])].size() < DEP);
    chk("in_ready", in_ready, e_rdy);
    for (int c = 0; c < NCH; c++) begin
      e_empty[c] = (mq[c].size() == 0);
      e_full[c]  = (mq[c].size() == DEP);
      e_afull[c] = (mq[c].size() >= AFT);
    end
    chk("ch_empty", ch_empty, e_empty);
    chk("ch_full", ch_full, e_full);
    chk("ch_afull", ch_afull, e_afull);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("out_valid", out_valid, m_ov);
    if (m_ov) begin
      chk("out_pkt", {out_id, out_src, out_dest, out_payload}, m_out);
      chk("out_ch", out_ch, m_ch);
    end
    chk("drop_cnt_bp", drop_cnt, 0);
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit v, input logic [31:0] id, input int ch, input bit ordy);
    logic [127:0] d;
    d = rnd128();
    d[1:0] = ch[1:0];
    in_valid   = v;
    in_id      = id;
    in_src     = rnd128();
    in_dest    = d;
    in_payload = rnd128();
    out_ready  = ordy;
    tick();
  endtask

  initial begin
    logic [127:0] dd;
    int id_ctr;

    // Reset state
    rst = 1'b1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    model_reset();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ch_empty", ch_empty, 4'hF);
    chk("rst_ch_full", ch_full, 0);
    chk("rst_ch_afull", ch_afull, 0);
    chk("rst_out_data", {out_id, out_ch}, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_d_in_ready", d_in_ready, 0);
    rst = 1'b0;
    #1;
    chk("d_in_ready_up", d_in_ready, 1);
    @(negedge clk);

    // Drop mode: the output register takes id 0, channel 2 keeps DEPTH more, the rest drop.
    for (int i = 0; i < 20; i++) begin
      dd = rnd128(); dd[1:0] = 2'd2;
      d_in_valid = 1'b1; d_in_id = i; d_in_dest = dd;
      d_in_src = rnd128(); d_in_payload = rnd128();
      #1;
      chk("d_in_ready_push", d_in_ready, 1);
      if (i <= DEP) exp_q.push_back(i);
      @(posedge clk); @(negedge clk);
    end
    d_in_valid = 1'b0;
    #1;
    chk("d_drop_cnt", d_drop_cnt, 20 - (DEP + 1));
    chk("d_full2", d_ch_full[2], 1);
    for (int k = 0; k <= DEP; k++) begin
      chk("d_out_valid", d_out_valid, 1);
      chk("d_out_id", d_out_id, exp_q.pop_front());
      chk("d_out_ch", d_out_ch, 2);
      chk("d_afull2", d_ch_afull[2], (DEP - k) >= AFT);
      d_out_ready = 1'b1;
      @(posedge clk); @(negedge clk);
    end
    chk("d_drained", d_out_valid, 0);
    chk("d_empty", d_ch_empty, 4'hF);

    // Order: 17 packets to channel 0 fill the output register plus the whole channel.
    for (int i = 0; i <= DEP; i++) step(1'b1, i, 0, 1'b0);
    in_valid = 1'b0; in_dest = '0;
    #1;
    chk("order_full0", ch_full[0], 1);
    chk("order_in_ready0", in_ready, 0);
    @(negedge clk);
    step(1'b1, 32'hDEAD, 0, 1'b0);
    for (int k = 0; k <= DEP; k++) begin
      chk("order_id", out_id, k);
      chk("order_ch", out_ch, 0);
      step(1'b0, 0, 0, 1'b1);
    end

    // Round robin
    step(1'b1, 100, 0, 1'b0);
    step(1'b1, 101, 0, 1'b0);
    step(1'b1, 200, 1, 1'b0);
    step(1'b1, 201, 1, 1'b0);
    step(1'b1, 300, 3, 1'b0);
    exp_q = '{100, 200, 300, 101, 201};
    for (int k = 0; k < 5; k++) begin
      chk("rr_id", out_id, exp_q.pop_front());
      if (k < 4) step(1'b0, 0, 0, 1'b1);
    end
    chk("rr_empty", ch_empty, 4'hF);
    step(1'b0, 0, 0, 1'b1);

    // Backpressure hold
    step(1'b1, 7, 1, 1'b0);
    step(1'b1, 8, 1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 0, 0, 1'b0);
      chk("hold_id", out_id, 7);
      chk("hold_ch", out_ch, 1);
    end
    step(1'b0, 0, 0, 1'b1);
    chk("hold_next", out_id, 8);
    step(1'b0, 0, 0, 1'b1);

    // Latency from an idle block
    step(1'b1, 5, 2, 1'b1);
    chk("lat_n", out_valid, 0);
    step(1'b0, 0, 0, 1'b1);
    chk("lat_n1_valid", out_valid, 1);
    chk("lat_n1_id", out_id, 5);
    step(1'b0, 0, 0, 1'b1);

    // Streaming, then random traffic with light and heavy backpressure
    id_ctr = 1000;
    for (int i = 0; i < 1000; i++) step(1'b1, id_ctr++, i % 4, 1'b1);
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 1)), id_ctr++, $urandom_range(0, 3), $urandom_range(0, 3) != 0);
    for (int i = 0; i < 200; i++)
      step(1'b1, id_ctr++, $urandom_range(0, 3), $urandom_range(0, 3) == 0);
    for (int i = 0; i < 80; i++) step(1'b0, 0, 0, 1'b1);

    // Reset mid-operation; dut_d still holds a non-zero drop count
    for (int i = 0; i < 6; i++) step(1'b1, 50 + i, i % 3, 1'b0);
    rst = 1'b1;
    step(1'b0, 0, 0, 1'b0);
    rst = 1'b0;
    chk("mid_out_valid", out_valid, 0);
    chk("mid_empty", ch_empty, 4'hF);
    chk("mid_d_drop", d_drop_cnt, 0);
    step(1'b1, 9, 3, 1'b1);
    step(1'b0, 0, 0, 1'b1);
    chk("mid_first_id", out_id, 9);
    step(1'b0, 0, 0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
